// File: rtl/det_nxn_seq.sv
// Sequential determinant engine: fraction-free Bareiss elimination with row-swap pivoting, one element update per cycle.
// Optional macro DET_SAT_EN saturates det on overflow instead of truncating it.
module det_nxn_seq #(
  parameter int N     = 5,
  parameter int W     = 8,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       dim,
  input  logic [N*N*W-1:0] matrix,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     det,
  output logic             ovf,
  output logic             singular,
  output logic             err
);

  localparam int         PW    = 2 * ACC_W;
  localparam logic [2:0] N_DIM = 3'(N);

  typedef enum logic [1:0] {IDLE, PIVOT, ELIM, FINAL} state_t;

  state_t state, state_next;

  logic signed [ACC_W-1:0] a [N][N];
  logic [2:0]              n_r, k_r, r_r, i_r, j_r;
  logic signed [ACC_W-1:0] prev_r;
  logic                    sign_neg, sing_r, err_r;

  logic                    dim_bad, accept, pivot_nz, last_col, last_row, last_step;
  logic signed [PW-1:0]    akk_w, aij_w, aik_w, akj_w, prev_w, num_w;
  logic signed [ACC_W-1:0] quo, d_val, d_trunc_ext, a_last;
  logic                    d_ovf;
  logic [W-1:0]            d_out;

  function automatic logic signed [ACC_W-1:0] sext_elem(input logic [W-1:0] v);
    return {{(ACC_W-W){v[W-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] widen(input logic [ACC_W-1:0] v);
    return {{ACC_W{v[ACC_W-1]}}, v};
  endfunction

  assign dim_bad   = (dim == 3'd0) || (dim > N_DIM);
  assign accept    = start && !done;
  assign pivot_nz  = (a[r_r][k_r] != '0);
  assign last_col  = (j_r == n_r - 3'd1);
  assign last_row  = (i_r == n_r - 3'd1);
  assign last_step = (k_r + 3'd1 == n_r - 3'd1);
  assign a_last    = a[n_r - 3'd1][n_r - 3'd1];

  // Bareiss update; the quotient is exact, and the true result always fits ACC_W.
  always_comb begin
    akk_w  = widen(a[k_r][k_r]);
    aij_w  = widen(a[i_r][j_r]);
    aik_w  = widen(a[i_r][k_r]);
    akj_w  = widen(a[k_r][j_r]);
    prev_w = widen(prev_r);
    num_w  = akk_w * aij_w - aik_w * akj_w;
    quo    = ACC_W'(num_w / prev_w);
  end

  always_comb begin
    d_val = '0;
    if (!err_r && !sing_r) begin
      d_val = sign_neg ? -a_last : a_last;
    end
    d_trunc_ext = {{(ACC_W-W){d_val[W-1]}}, d_val[W-1:0]};
    d_ovf       = (d_trunc_ext != d_val);
    d_out       = d_val[W-1:0];
`ifdef DET_SAT_EN
    if (d_ovf) begin
      d_out = d_val[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = (dim_bad || dim == 3'd1) ? FINAL : PIVOT;
      end
      PIVOT: begin
        if (pivot_nz)                  state_next = ELIM;
        else if (r_r == n_r - 3'd1)    state_next = FINAL;
      end
      ELIM: begin
        if (last_row && last_col) state_next = last_step ? FINAL : PIVOT;
      end
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Invalid sizes are folded to n=1 so the final read stays in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      det      <= '0;
      ovf      <= 1'b0;
      singular <= 1'b0;
      err      <= 1'b0;
      n_r      <= 3'd1;
      k_r      <= 3'd0;
      r_r      <= 3'd0;
      i_r      <= 3'd1;
      j_r      <= 3'd1;
      prev_r   <= ACC_W'(1);
      sign_neg <= 1'b0;
      sing_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            for (int rr = 0; rr < N; rr++) begin
              for (int cc = 0; cc < N; cc++) begin
                a[rr][cc] <= sext_elem(matrix[N*N*W-1 - (rr*N+cc)*W -: W]);
              end
            end
            n_r      <= dim_bad ? 3'd1 : dim;
            k_r      <= 3'd0;
            r_r      <= 3'd0;
            i_r      <= 3'd1;
            j_r      <= 3'd1;
            prev_r   <= ACC_W'(1);
            sign_neg <= 1'b0;
            sing_r   <= 1'b0;
            err_r    <= dim_bad;
            busy     <= 1'b1;
          end
        end
        PIVOT: begin
          if (pivot_nz) begin
            if (r_r != k_r) begin
              for (int cc = 0; cc < N; cc++) begin
                a[k_r][cc] <= a[r_r][cc];
                a[r_r][cc] <= a[k_r][cc];
              end
              sign_neg <= ~sign_neg;
            end
            i_r <= k_r + 3'd1;
            j_r <= k_r + 3'd1;
          end else if (r_r == n_r - 3'd1) begin
            sing_r <= 1'b1;
          end else begin
            r_r <= r_r + 3'd1;
          end
        end
        ELIM: begin
          a[i_r][j_r] <= quo;
          if (!last_col) begin
            j_r <= j_r + 3'd1;
          end else begin
            j_r <= k_r + 3'd1;
            if (!last_row) begin
              i_r <= i_r + 3'd1;
            end else begin
              prev_r <= a[k_r][k_r];
              k_r    <= k_r + 3'd1;
              r_r    <= k_r + 3'd1;
            end
          end
        end
        FINAL: begin
          det      <= d_out;
          ovf      <= d_ovf;
          singular <= (d_val == '0) && !err_r;
          err      <= err_r;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_det_nxn_seq.sv
// Self-checking bench for det_nxn_seq: directed vector table, randomized matrices against a
// Leibniz-formula reference model, and hand-written control sequences (busy, done-cycle start, abort).
module tb_det_nxn_seq;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int MW = N * N * W;
  localparam int BUDGET = 200;

`ifdef DET_SAT_EN
  localparam logic [7:0] DET_10000 = 8'h7F;
  localparam logic [7:0] DET_128   = 8'h7F;
`else
  localparam logic [7:0] DET_10000 = 8'h10;
  localparam logic [7:0] DET_128   = 8'h80;
`endif

  typedef longint mat_t [0:6][0:6];

  typedef struct packed {
    logic [MW-1:0] mat;
    logic [2:0]    dim;
    logic [7:0]    det;
    logic          ovf;
    logic          sing;
    logic          err;
    int            lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [2:0]    dim;
  logic [MW-1:0] matrix;
  logic          busy, done, ovf, singular, err;
  logic [W-1:0]  det;

  int checks   = 0;
  int failures = 0;

  vec_t tbl [10];

  always #5 clk = ~clk;

  det_nxn_seq #(.N(N), .W(W), .ACC_W(48)) dut (
    .clk(clk), .rst(rst), .start(start), .dim(dim), .matrix(matrix),
    .busy(busy), .done(done), .det(det), .ovf(ovf), .singular(singular), .err(err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] row5(input int e0, input int e1, input int e2, input int e3, input int e4);
    return {8'(e0), 8'(e1), 8'(e2), 8'(e3), 8'(e4)};
  endfunction

  function automatic logic [MW-1:0] rand_fill();
    logic [MW-1:0] v;
    for (int e = 0; e < N*N; e++) v[e*W +: W] = W'($urandom);
    return v;
  endfunction

  function automatic longint elem(input logic [MW-1:0] m, input int r, input int c);
    logic [7:0] v;
    v = m[MW-1 - (r*N+c)*W -: W];
    return longint'(signed'(v));
  endfunction

  // Determinant as the signed sum over all permutations of the leading sz x sz block.
  function automatic longint leib(input mat_t m, input int sz);
    int     p [7];
    longint tot = 0;
    int     lim = 1;
    for (int i = 0; i < sz; i++) lim *= sz;
    for (int code = 0; code < lim; code++) begin
      int     c;
      bit     ok;
      int     inv;
      longint prod;
      c = code; ok = 1'b1; inv = 0; prod = 1;
      for (int i = 0; i < sz; i++) begin
        p[i] = c % sz;
        c    = c / sz;
      end
      for (int i = 0; i < sz; i++)
        for (int j = i + 1; j < sz; j++) begin
          if (p[i] == p[j]) ok = 1'b0;
          else if (p[i] > p[j]) inv++;
        end
      if (ok) begin
        for (int i = 0; i < sz; i++) prod *= m[i][p[i]];
        tot += (inv % 2 != 0) ? -prod : prod;
      end
    end
    return tot;
  endfunction

  // Pivot at step k is the first remaining row whose leading (k+1)x(k+1) minor is nonzero.
  task automatic model(input logic [MW-1:0] m, input logic [2:0] d, output longint dval, output int lat);
    mat_t a, s;
    int   perm [7];
    int   n, found;
    n = int'(d);
    dval = 0;
    lat  = 1;
    if (n == 0 || n > N) return;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        a[r][c] = (r < N && c < N) ? elem(m, r, c) : 0;
        s[r][c] = 0;
      end
    dval = leib(a, n);
    for (int i = 0; i < 7; i++) perm[i] = i;
    for (int k = 0; k < n - 1; k++) begin
      found = -1;
      for (int r = k; r < n && found < 0; r++) begin
        for (int x = 0; x < k; x++)
          for (int y = 0; y <= k; y++) s[x][y] = a[perm[x]][y];
        for (int y = 0; y <= k; y++) s[k][y] = a[perm[r]][y];
        if (leib(s, k + 1) != 0) found = r;
      end
      if (found < 0) begin
        lat += n - k;
        break;
      end
      lat += found - k + 1 + (n - 1 - k) * (n - 1 - k);
      begin
        int t;
        t = perm[k]; perm[k] = perm[found]; perm[found] = t;
      end
    end
  endtask

  // Starts one job and waits for done; optionally re-pulses start while busy at cycle poke.
  task automatic applyStimulus(input logic [MW-1:0] m, input logic [2:0] d, input int poke,
                               output int lat, output bit timed_out);
    start  = 1'b1;
    matrix = m;
    dim    = d;
    @(posedge clk); #1;
    start  = 1'b0;
    matrix = rand_fill();
    dim    = 3'($urandom);
    checkOutput("busy_after_accept", {63'd0, busy}, 64'd1);
    lat = 0;
    timed_out = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        timed_out = 1'b0;
        break;
      end
      if (c == poke) begin
        start  = 1'b1;
        matrix = rand_fill();
        dim    = 3'd5;
      end else if (c == poke + 1) begin
        start  = 1'b0;
      end
    end
    start = 1'b0;
    if (timed_out) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles", BUDGET);
    end
  endtask

  task automatic checkResult(input string tag, input logic [7:0] e_det, input logic e_ovf,
                             input logic e_sing, input logic e_err, input int e_lat, input int g_lat);
    checkOutput($sformatf("%s.det", tag),      {56'd0, det},           {56'd0, e_det});
    checkOutput($sformatf("%s.ovf", tag),      {63'd0, ovf},           {63'd0, e_ovf});
    checkOutput($sformatf("%s.singular", tag), {63'd0, singular},      {63'd0, e_sing});
    checkOutput($sformatf("%s.err", tag),      {63'd0, err},           {63'd0, e_err});
    checkOutput($sformatf("%s.latency", tag),  64'(g_lat),             64'(e_lat));
    checkOutput($sformatf("%s.busy_low", tag), {63'd0, busy},          64'd0);
  endtask

  function automatic logic [7:0] expect_det(input longint dv);
    logic [63:0] bits;
    bits = dv;
`ifdef DET_SAT_EN
    if (dv > 127)  return 8'h7F;
    if (dv < -128) return 8'h80;
`endif
    return bits[7:0];
  endfunction

  initial begin
    int     lat;
    bit     to;
    logic [7:0] held;

    tbl[0] = '{{row5(1,0,0,9,9), row5(0,1,0,9,9), row5(0,0,1,9,9), row5(9,9,9,9,9), row5(9,9,9,9,9)},
               3'd3, 8'h01, 1'b0, 1'b0, 1'b0, 8};
    tbl[1] = '{{row5(0,1,0,0,0), row5(1,0,0,0,0), row5(0,0,0,0,0), row5(0,0,0,0,0), row5(0,0,0,0,0)},
               3'd2, 8'hFF, 1'b0, 1'b0, 1'b0, 4};
    tbl[2] = '{{row5(1,2,3,0,0), row5(2,4,6,0,0), row5(1,1,1,0,0), row5(0,0,0,0,0), row5(0,0,0,0,0)},
               3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 9};
    tbl[3] = '{{row5(100,0,0,0,0), row5(0,100,0,0,0), row5(0,0,0,0,0), row5(0,0,0,0,0), row5(0,0,0,0,0)},
               3'd2, DET_10000, 1'b1, 1'b0, 1'b0, 3};
    tbl[4] = '{{row5(-2,0,0,0,0), row5(0,4,0,0,0), row5(0,0,4,0,0), row5(0,0,0,4,0), row5(0,0,0,0,1)},
               3'd5, 8'h80, 1'b0, 1'b0, 1'b0, 35};
    tbl[5] = '{{row5(2,0,0,0,0), row5(0,4,0,0,0), row5(0,0,4,0,0), row5(0,0,0,4,0), row5(0,0,0,0,1)},
               3'd5, DET_128, 1'b1, 1'b0, 1'b0, 35};
    tbl[6] = '{{row5(3,1,0,0,0), row5(1,3,0,0,0), row5(0,0,1,0,0), row5(0,0,0,1,0), row5(0,0,0,0,1)},
               3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    tbl[7] = '{{row5(3,1,0,0,0), row5(1,3,0,0,0), row5(0,0,1,0,0), row5(0,0,0,1,0), row5(0,0,0,0,1)},
               3'd6, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    tbl[8] = '{{row5(-5,7,7,7,7), row5(7,7,7,7,7), row5(7,7,7,7,7), row5(7,7,7,7,7), row5(7,7,7,7,7)},
               3'd1, 8'hFB, 1'b0, 1'b0, 1'b0, 1};
    tbl[9] = '{{row5(0,0,0,5,5), row5(0,0,0,5,5), row5(0,0,0,5,5), row5(5,5,5,5,5), row5(5,5,5,5,5)},
               3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 4};

    rst    = 1'b1;
    start  = 1'b0;
    dim    = 3'd0;
    matrix = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy",     {63'd0, busy},     64'd0);
    checkOutput("reset.done",     {63'd0, done},     64'd0);
    checkOutput("reset.det",      {56'd0, det},      64'd0);
    checkOutput("reset.ovf",      {63'd0, ovf},      64'd0);
    checkOutput("reset.singular", {63'd0, singular}, 64'd0);
    checkOutput("reset.err",      {63'd0, err},      64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      applyStimulus(tbl[v].mat, tbl[v].dim, 0, lat, to);
      checkResult($sformatf("vec%0d", v), tbl[v].det, tbl[v].ovf, tbl[v].sing, tbl[v].err, tbl[v].lat, lat);
      held = det;
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d.done_pulse", v), {63'd0, done}, 64'd0);
      checkOutput($sformatf("vec%0d.det_hold", v),   {56'd0, det},  {56'd0, tbl[v].det});
    end

    for (int t = 0; t < 40; t++) begin
      logic [MW-1:0] m;
      logic [2:0]    d;
      int            mode, rr, elat;
      longint        dv;
      logic          e_err;
      m = rand_fill();
      mode = $urandom_range(0, 2);
      if (mode != 0)
        for (int e = 0; e < N*N; e++) m[e*W +: W] = W'(int'($urandom_range(0, 4)) - 2);
      if (mode == 2) begin
        rr = $urandom_range(1, N - 1);
        for (int c = 0; c < N; c++) m[MW-1 - (rr*N+c)*W -: W] = m[MW-1 - c*W -: W];
      end
      if ($urandom_range(0, 9) == 0) d = 3'($urandom_range(6, 8) % 8);
      else                           d = 3'($urandom_range(1, 5));
      model(m, d, dv, elat);
      e_err = (d == 3'd0) || (int'(d) > N);
      applyStimulus(m, d, 0, lat, to);
      checkResult($sformatf("rand%0d", t), expect_det(dv), (dv > 127) || (dv < -128),
                  (dv == 0) && !e_err, e_err, elat, lat);
      @(posedge clk); #1;
    end

    // start pulsed mid-run must not disturb the job in flight
    applyStimulus(tbl[0].mat, 3'd3, 3, lat, to);
    checkResult("busy_start", 8'h01, 1'b0, 1'b0, 1'b0, 8, lat);
    @(posedge clk); #1;

    // reset during ELIM aborts silently, then a fresh job runs normally
    start  = 1'b1;
    matrix = tbl[4].mat;
    dim    = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort.busy", {63'd0, busy}, 64'd0);
    checkOutput("abort.done", {63'd0, done}, 64'd0);
    checkOutput("abort.det",  {56'd0, det},  64'd0);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      checkOutput("abort.no_done", 64'(seen), 64'd0);
    end
    applyStimulus(tbl[4].mat, 3'd5, 0, lat, to);
    checkResult("after_abort", 8'h80, 1'b0, 1'b0, 1'b0, 35, lat);

    // start held during the done cycle is only taken on the following edge
    start  = 1'b1;
    matrix = tbl[6].mat;
    dim    = 3'd0;
    @(posedge clk); #1;
    checkOutput("done_cycle.not_accepted", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("done_cycle.accepted", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    checkOutput("done_cycle.done", {63'd0, done}, 64'd1);
    checkOutput("done_cycle.err",  {63'd0, err},  64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
